// File: rtl/sym_vn_pkg.sv
// sym_vn_pkg: default widths and the symmetric (y0, y1) fold shared by the VN LUT pipe.
package sym_vn_pkg;
    localparam int DEF_QUAN_SIZE = 4;
    localparam int DEF_IDX_W = 2*DEF_QUAN_SIZE-1;
    localparam int DEF_PAGE_NUM = 2;
    localparam int PAGE_W = $clog2(DEF_PAGE_NUM);

    // Returns {s, y0f, y1f}; the low IDX_W bits are the folded LUT index.
    function automatic logic [DEF_IDX_W:0] fold_idx(
        input logic [DEF_QUAN_SIZE-1:0] y0,
        input logic [DEF_QUAN_SIZE-1:0] y1,
        input logic ten
    );
        logic s;
        s = y0[DEF_QUAN_SIZE-1] ^ ten;
        return {s, y0[DEF_QUAN_SIZE-2:0] ^ {(DEF_QUAN_SIZE-1){y0[DEF_QUAN_SIZE-1]}}, s ? ~y1 : y1};
    endfunction
endpackage

// File: rtl/sym_vn_lut_mem.sv
// sym_vn_lut_mem: paged LUT with N_LANE gated read-first synchronous read ports and one write port.
module sym_vn_lut_mem import sym_vn_pkg::*; #(
    parameter int N_LANE = 4,
    parameter int QUAN_SIZE = DEF_QUAN_SIZE,
    parameter int PAGE_NUM = DEF_PAGE_NUM,
    parameter int IDX_W = 2*QUAN_SIZE-1,
    parameter int PG_W = $clog2(PAGE_NUM)
) (
    input  logic                        sys_clk,
    input  logic                        rstn,
    input  logic                        ren,
    input  logic [PG_W-1:0]             rd_page,
    input  logic [N_LANE*IDX_W-1:0]     rd_idx,
    output logic [N_LANE*QUAN_SIZE-1:0] rd_data,
    input  logic                        we,
    input  logic [PG_W-1:0]             wr_page,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [QUAN_SIZE-1:0]        wr_data
);
    logic [QUAN_SIZE-1:0] mem [PAGE_NUM*(1<<IDX_W)];

    always_ff @(posedge sys_clk)
        if (we) mem[{wr_page, wr_idx}] <= wr_data;

    // Non-blocking read alongside the write gives old data on a same-entry collision.
    always_ff @(posedge sys_clk or negedge rstn)
        if (!rstn) rd_data <= '0;
        else if (ren)
            for (int i = 0; i < N_LANE; i++)
                rd_data[i*QUAN_SIZE +: QUAN_SIZE] <= mem[{rd_page, rd_idx[i*IDX_W +: IDX_W]}];
endmodule

// File: rtl/sym_vn_lut_pipe.sv
// sym_vn_lut_pipe: 2-stage symmetric VN LUT output stage with valid/ready stall.
// SYM_VN_LUT_WR_GUARD_EN rejects LUT writes to pages with beats in flight and flags them on wr_err.
module sym_vn_lut_pipe import sym_vn_pkg::*; #(
    parameter int N_LANE = 4,
    parameter int QUAN_SIZE = DEF_QUAN_SIZE,
    parameter int PAGE_NUM = DEF_PAGE_NUM,
    localparam int IDX_W = 2*QUAN_SIZE-1,
    localparam int PG_W = $clog2(PAGE_NUM)
) (
    input  logic                        sys_clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_LANE-1:0]           transpose_en_in,
    input  logic [N_LANE*QUAN_SIZE-1:0] y0_in,
    input  logic [N_LANE*QUAN_SIZE-1:0] y1_in,
    input  logic [PG_W-1:0]             read_page,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LANE*QUAN_SIZE-1:0] t_c,
    output logic [N_LANE*QUAN_SIZE-1:0] t_c_din,
    output logic [N_LANE-1:0]           transpose_en_out,
    output logic [PG_W-1:0]             read_page_out,
    input  logic                        wr_en,
    input  logic [PG_W-1:0]             wr_page,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [QUAN_SIZE-1:0]        wr_data,
    output logic                        wr_err
);
    localparam int Q = QUAN_SIZE;

    logic adv, v0, v1, we;
    logic [N_LANE-1:0] s_c, s0, s1;
    logic [N_LANE*(Q-1)-1:0] y0f_c, y0f_q;
    logic [N_LANE*Q-1:0] y1f_c, y1f_q, data;
    logic [N_LANE*IDX_W-1:0] idx;
    logic [PG_W-1:0] p0, p1;

    assign adv = !v1 || out_ready;
    assign in_ready = adv;
    assign out_valid = v1;
    assign t_c_din = data;
    assign transpose_en_out = s1;
    assign read_page_out = p1;

    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        if (Q == DEF_QUAN_SIZE) begin : g_fold
            assign {s_c[i], y0f_c[i*(Q-1) +: Q-1], y1f_c[i*Q +: Q]} =
                fold_idx(y0_in[i*Q +: Q], y1_in[i*Q +: Q], transpose_en_in[i]);
        end else begin : g_fold
            assign s_c[i] = y0_in[i*Q+Q-1] ^ transpose_en_in[i];
            assign y0f_c[i*(Q-1) +: Q-1] = y0_in[i*Q +: Q-1] ^ {(Q-1){y0_in[i*Q+Q-1]}};
            assign y1f_c[i*Q +: Q] = s_c[i] ? ~y1_in[i*Q +: Q] : y1_in[i*Q +: Q];
        end
        assign idx[i*IDX_W +: IDX_W] = {y0f_q[i*(Q-1) +: Q-1], y1f_q[i*Q +: Q]};
        assign t_c[i*Q +: Q] = s1[i] ? ~data[i*Q +: Q] : data[i*Q +: Q];
    end

    always_ff @(posedge sys_clk or negedge rstn)
        if (!rstn) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            y0f_q <= '0;
            y1f_q <= '0;
            s0 <= '0;
            s1 <= '0;
            p0 <= '0;
            p1 <= '0;
        end else if (adv) begin
            v0 <= in_valid;
            v1 <= v0;
            y0f_q <= y0f_c;
            y1f_q <= y1f_c;
            s0 <= s_c;
            p0 <= read_page;
            s1 <= s0;
            p1 <= p0;
        end

`ifdef SYM_VN_LUT_WR_GUARD_EN
    logic rej;
    assign rej = wr_en && ((v0 && p0 == wr_page) || (v1 && p1 == wr_page) ||
                           (in_valid && adv && read_page == wr_page));
    assign we = wr_en && !rej;
    always_ff @(posedge sys_clk or negedge rstn)
        if (!rstn) wr_err <= 1'b0;
        else wr_err <= rej;
`else
    assign we = wr_en;
    assign wr_err = 1'b0;
`endif

    sym_vn_lut_mem #(
        .N_LANE(N_LANE), .QUAN_SIZE(Q), .PAGE_NUM(PAGE_NUM), .IDX_W(IDX_W), .PG_W(PG_W)
    ) u_mem (
        .sys_clk(sys_clk),
        .rstn(rstn),
        .ren(adv),
        .rd_page(p0),
        .rd_idx(idx),
        .rd_data(data),
        .we(we),
        .wr_page(wr_page),
        .wr_idx(wr_idx),
        .wr_data(wr_data)
    );
endmodule

// File: tb/tb_sym_vn_lut_pipe.sv
// tb_sym_vn_lut_pipe: randomized checks of sym_vn_lut_pipe against an arithmetic fold/LUT model.
module tb_sym_vn_lut_pipe;
    typedef struct packed {
        logic [15:0] tc;
        logic [15:0] din;
        logic [3:0]  ten;
        logic        pg;
    } exp_t;

    logic sys_clk = 0, rstn = 0, in_valid = 0, out_ready = 1, wr_en = 0;
    logic [3:0] transpose_en_in = 0;
    logic [15:0] y0_in = 0, y1_in = 0;
    logic read_page = 0, wr_page = 0;
    logic [6:0] wr_idx = 0;
    logic [3:0] wr_data = 0;
    logic in_ready, out_valid, read_page_out, wr_err;
    logic [15:0] t_c, t_c_din;
    logic [3:0] transpose_en_out;

    logic [3:0] lut [2][128];
    int checks = 0, errors = 0;

    always #5 sys_clk = ~sys_clk;

    sym_vn_lut_pipe dut (
        .sys_clk(sys_clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .transpose_en_in(transpose_en_in), .y0_in(y0_in), .y1_in(y1_in), .read_page(read_page),
        .out_valid(out_valid), .out_ready(out_ready), .t_c(t_c), .t_c_din(t_c_din),
        .transpose_en_out(transpose_en_out), .read_page_out(read_page_out),
        .wr_en(wr_en), .wr_page(wr_page), .wr_idx(wr_idx), .wr_data(wr_data), .wr_err(wr_err)
    );

    // Negative y0 mirrors onto the positive half (15-a); y1 is complemented when the fold sign is set.
    function automatic int fidx(input int a, input int b, input bit ten);
        bit s;
        s = (a >= 8) ^ ten;
        return (a >= 8 ? 15 - a : a) * 16 + (s ? 15 - b : b);
    endfunction

    function automatic exp_t model(input logic [15:0] y0, input logic [15:0] y1, input logic [3:0] ten, input logic pg);
        exp_t m;
        int a, b, d;
        bit s;
        for (int i = 0; i < 4; i++) begin
            a = int'(y0[i*4 +: 4]);
            b = int'(y1[i*4 +: 4]);
            s = (a >= 8) ^ ten[i];
            d = int'(lut[pg][fidx(a, b, ten[i])]);
            m.tc[i*4 +: 4] = 4'(s ? 15 - d : d);
            m.din[i*4 +: 4] = 4'(d);
            m.ten[i] = s;
        end
        m.pg = pg;
        return m;
    endfunction

    task automatic wr(input logic pg, input int idx, input logic [3:0] d);
        @(negedge sys_clk);
        wr_en = 1; wr_page = pg; wr_idx = 7'(idx); wr_data = d;
        @(negedge sys_clk);
        wr_en = 0;
        lut[pg][idx] = d;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({out_valid, t_c, t_c_din, transpose_en_out, read_page_out, wr_err} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {out_valid, t_c, t_c_din, transpose_en_out, read_page_out, wr_err});
        end
        rstn = 1;
        @(negedge sys_clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_lookup(input bit ten);
        exp_t e;
        int k;
        logic [15:0] y0, y1;
        logic [3:0] tv;
        y0 = 16'($urandom); y0[3:0] = 4'b1010;
        y1 = 16'($urandom); y1[3:0] = 4'b0011;
        tv = 4'($urandom); tv[0] = ten;
        k = fidx(10, 3, ten);
        if (!ten) wr(1'b0, k, 4'b0110);
        e = model(y0, y1, tv, 1'b0);
        @(negedge sys_clk);
        in_valid = 1; y0_in = y0; y1_in = y1; transpose_en_in = tv; read_page = 0; out_ready = 1;
        @(negedge sys_clk);
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lookup_early got out_valid=%b want 0", out_valid);
        end
        @(negedge sys_clk);
        checks++;
        if (out_valid !== 1'b1 || {t_c, t_c_din, transpose_en_out, read_page_out} !== e) begin
            errors++;
            $display("FAIL lookup_t%0d got v=%b %h %h %h %b want 1 %h %h %h %b", ten, out_valid,
                     t_c, t_c_din, transpose_en_out, read_page_out, e.tc, e.din, e.ten, e.pg);
        end
        checks++;
        if (!ten ? (t_c[3:0] !== 4'b1001 || transpose_en_out[0] !== 1'b1) : (t_c[3:0] !== t_c_din[3:0])) begin
            errors++;
            $display("FAIL lookup_lane0_t%0d got t_c=%h din=%h s=%b", ten, t_c[3:0], t_c_din[3:0], transpose_en_out[0]);
        end
        @(negedge sys_clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lookup_bubble got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream(input int n, input bit alt, input bit bp);
        exp_t q[$];
        exp_t e;
        int sent, got, cyc;
        logic [3:0] pat;
        sent = 0; got = 0; cyc = 0; pat = 4'b1001;
        while (got < n && cyc < 400) begin
            @(negedge sys_clk);
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            if (sent < n && (!bp || $urandom_range(0, 3) != 0)) begin
                in_valid = 1;
                y0_in = 16'($urandom); y1_in = 16'($urandom); transpose_en_in = 4'($urandom);
                read_page = alt ? sent[0] : 1'($urandom);
            end else in_valid = 0;
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL stream_in_ready got %b want %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_spurious got out_valid=1 want 0");
                end else begin
                    e = q.pop_front();
                    if ({t_c, t_c_din, transpose_en_out, read_page_out} !== e) begin
                        errors++;
                        $display("FAIL stream_data beat %0d got %h %h %h %b want %h %h %h %b", got,
                                 t_c, t_c_din, transpose_en_out, read_page_out, e.tc, e.din, e.ten, e.pg);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(y0_in, y1_in, transpose_en_in, read_page));
                sent++;
            end
            cyc++;
        end
        in_valid = 0; out_ready = 1;
        checks++;
        if (got != n || q.size() != 0 || (!bp && cyc != n + 2)) begin
            errors++;
            $display("FAIL stream_count got %0d beats in %0d cycles left %0d want %0d", got, cyc, q.size(), n);
        end
    endtask

    task automatic test_collision();
        int k;
        logic [3:0] old, want;
        logic [15:0] y0, y1;
        y0 = 16'($urandom); y1 = 16'($urandom);
        k = fidx(int'(y0[3:0]), int'(y1[3:0]), 1'b0);
        if (lut[0][k] == 4'hF) wr(1'b0, k, 4'h5);
        old = lut[0][k];
        @(negedge sys_clk);
        in_valid = 1; y0_in = y0; y1_in = y1; transpose_en_in = 0; read_page = 0; out_ready = 1;
        @(negedge sys_clk);
        in_valid = 0; wr_en = 1; wr_page = 0; wr_idx = 7'(k); wr_data = 4'hF;
        @(negedge sys_clk);
        wr_en = 0;
        checks++;
        if (out_valid !== 1'b1 || t_c_din[3:0] !== old) begin
            errors++;
            $display("FAIL collision_old got v=%b %h want 1 %h", out_valid, t_c_din[3:0], old);
        end
`ifdef SYM_VN_LUT_WR_GUARD_EN
        want = old;
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL collision_wr_err got %b want 1", wr_err);
        end
`else
        want = 4'hF;
        lut[0][k] = 4'hF;
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL collision_wr_err got %b want 0", wr_err);
        end
`endif
        in_valid = 1;
        @(negedge sys_clk);
        in_valid = 0;
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL collision_err_pulse got %b want 0", wr_err);
        end
        @(negedge sys_clk);
        checks++;
        if (out_valid !== 1'b1 || t_c_din[3:0] !== want) begin
            errors++;
            $display("FAIL collision_reread got v=%b %h want 1 %h", out_valid, t_c_din[3:0], want);
        end
    endtask

    task automatic test_async_reset();
        @(negedge sys_clk);
        in_valid = 1; y0_in = 16'($urandom); y1_in = 16'($urandom); transpose_en_in = 4'hF; read_page = 1; out_ready = 1;
        @(negedge sys_clk);
        y0_in = 16'($urandom); y1_in = 16'($urandom);
        @(negedge sys_clk);
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_inflight got out_valid=%b want 1", out_valid);
        end
        #2 rstn = 0;
        #1;
        checks++;
        if ({out_valid, t_c, t_c_din, transpose_en_out, read_page_out, wr_err} !== 39'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_outputs got %h rdy=%b want 0 1",
                     {out_valid, t_c, t_c_din, transpose_en_out, read_page_out, wr_err}, in_ready);
        end
        @(negedge sys_clk);
        #2 rstn = 1;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_release got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        test_stream(6, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 128; k++) wr(1'(p), k, 4'($urandom));
        test_lookup(1'b0);
        test_lookup(1'b1);
        test_stream(8, 1'b0, 1'b1);
        test_stream(12, 1'b1, 1'b0);
        test_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
